// File: rtl/stopwatch_bcd_counter_if.sv
// Button inputs and display outputs of the stopwatch, bundled for the
// push-button side (master) and the stopwatch core (slave).
interface stopwatch_bcd_counter_if;
    logic        btn_start_stop;
    logic        btn_clear;
    logic [15:0] bcd_value;
    logic        running;

    modport master (
        output btn_start_stop,
        output btn_clear,
        input  bcd_value,
        input  running
    );

    modport slave (
        input  btn_start_stop,
        input  btn_clear,
        output bcd_value,
        output running
    );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// Four-digit BCD stopwatch (SS.cc) with synchronised, debounced start/stop and
// clear buttons, a run/pause FSM and a tick prescaler.
module stopwatch_bcd_counter #(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    stopwatch_bcd_counter_if.slave  bus
);
    localparam int PRESC_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int PW        = $clog2(PRESC_MAX + 2);
    localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_MAX);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state;
    logic [1:0]    btn_raw;
    logic [1:0]    btn_p0;
    logic [1:0]    btn_p1;
    logic [1:0]    lvl_p2;
    logic [1:0]    lvl_q;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    press;
    logic          press_ss;
    logic          press_clr;
    logic          tick;
    logic [PW-1:0] presc;
    logic [15:0]   bcd_q;
    logic          run_q;

    // Decimal increment; any digit at 9 (or out of range) wraps to 0 and carries.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (v[4*d +: 4] >= 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign btn_raw = {bus.btn_clear, bus.btn_start_stop};

    // p0/p1: synchroniser, p2: debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            lvl_p2 <= '0;
            lvl_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            btn_p0 <= btn_raw;
            btn_p1 <= btn_p0;
            lvl_q  <= lvl_p2;
            for (int i = 0; i < 2; i++) begin
                if (btn_p1[i] != lvl_p2[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        lvl_p2[i]  <= btn_p1[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign press     = lvl_p2 & ~lvl_q;
    assign press_ss  = press[0];
    assign press_clr = press[1];
    assign tick      = (state == RUN) && (presc == PRESC_LAST);

    // Run control; clear overrides a simultaneous start/stop press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            run_q <= 1'b0;
            presc <= '0;
            bcd_q <= '0;
        end else if (press_clr) begin
            state <= IDLE;
            run_q <= 1'b0;
            presc <= '0;
            bcd_q <= '0;
        end else begin
            if (state == RUN) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    bcd_q <= bcd_inc(bcd_q);
                end
            end
            if (press_ss) begin
                case (state)
                    IDLE: begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end
                    RUN: begin
                        state <= PAUSED;
                        run_q <= 1'b0;
                    end
                    PAUSED: begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        run_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bcd_value = bcd_q;
    assign bus.running   = run_q;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: directed sequences, a vector table and
// randomised button activity against an arithmetic reference model.
module tb_stopwatch_bcd_counter;
    localparam int NT  = 10;
    localparam int DEB = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stopwatch_bcd_counter_if if_a ();
    stopwatch_bcd_counter_if if_f ();

    stopwatch_bcd_counter #(
        .CLK_FREQ_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(DEB)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(if_a)
    );

    // One tick per clock, used only to reach the 99.99 wrap quickly.
    stopwatch_bcd_counter #(
        .CLK_FREQ_HZ(10), .TICK_HZ(10), .DEBOUNCE_CYCLES(DEB)
    ) u_fast (
        .clk(clk), .rst(rst), .bus(if_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: elapsed hundredths as an integer, mode 0=idle 1=run 2=paused.
    int m_mode;
    int m_phase;
    int m_hund;
    int m_diff [2];
    bit m_d1   [2];
    bit m_d2   [2];
    bit m_acc  [2];
    bit m_rise [2];

    always @(posedge clk) begin
        bit raw [2];
        bit p_ss;
        bit p_clr;
        bit synced;
        raw[0] = if_a.btn_start_stop;
        raw[1] = if_a.btn_clear;
        if (rst) begin
            m_mode  = 0;
            m_phase = 0;
            m_hund  = 0;
            for (int b = 0; b < 2; b++) begin
                m_diff[b] = 0;
                m_d1[b]   = 0;
                m_d2[b]   = 0;
                m_acc[b]  = 0;
                m_rise[b] = 0;
            end
        end else begin
            p_ss  = m_rise[0];
            p_clr = m_rise[1];
            if (p_clr) begin
                m_mode  = 0;
                m_phase = 0;
                m_hund  = 0;
            end else begin
                if (m_mode == 1) begin
                    m_phase = m_phase + 1;
                    if (m_phase == NT) begin
                        m_phase = 0;
                        m_hund  = (m_hund + 1) % 10000;
                    end
                end
                if (p_ss) m_mode = (m_mode == 1) ? 2 : 1;
            end
            for (int b = 0; b < 2; b++) begin
                synced    = m_d2[b];
                m_d2[b]   = m_d1[b];
                m_d1[b]   = raw[b];
                m_rise[b] = 0;
                if (synced != m_acc[b]) begin
                    m_diff[b] = m_diff[b] + 1;
                    if (m_diff[b] == DEB) begin
                        m_acc[b]  = synced;
                        m_diff[b] = 0;
                        m_rise[b] = synced;
                    end
                end else begin
                    m_diff[b] = 0;
                end
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Holds the given buttons for exactly the press latency, returns just after
    // the resulting state change and releases them.
    task automatic tap(input bit ss, input bit clr);
        if_a.btn_start_stop = ss;
        if_a.btn_clear      = clr;
        repeat (7) @(negedge clk);
        if_a.btn_start_stop = 1'b0;
        if_a.btn_clear      = 1'b0;
    endtask

    typedef struct {
        int          run_clks;
        logic [15:0] exp_bcd;
        logic        exp_run;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int hold_ss;
        int hold_clr;
        checks = 0;
        errors = 0;
        vecs[0] = '{0,    16'h0000, 1'b1};
        vecs[1] = '{9,    16'h0000, 1'b1};
        vecs[2] = '{10,   16'h0001, 1'b1};
        vecs[3] = '{95,   16'h0009, 1'b1};
        vecs[4] = '{100,  16'h0010, 1'b1};
        vecs[5] = '{990,  16'h0099, 1'b1};
        vecs[6] = '{1000, 16'h0100, 1'b1};

        rst = 1'b1;
        if_a.btn_start_stop = 1'b0;
        if_a.btn_clear      = 1'b0;
        if_f.btn_start_stop = 1'b0;
        if_f.btn_clear      = 1'b0;

        // Reset held with buttons toggling
        repeat (3) begin
            @(negedge clk);
            check("rst_bcd", if_a.bcd_value, 16'h0000);
            check("rst_run", {15'd0, if_a.running}, 16'd0);
            if_a.btn_start_stop = ~if_a.btn_start_stop;
            if_a.btn_clear      = ~if_a.btn_clear;
        end
        @(negedge clk);
        rst = 1'b0;
        if_a.btn_start_stop = 1'b0;
        if_a.btn_clear      = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_bcd", if_a.bcd_value, 16'h0000);
        check("post_rst_run", {15'd0, if_a.running}, 16'd0);

        // Short glitch is ignored
        if_a.btn_start_stop = 1'b1;
        repeat (3) @(negedge clk);
        if_a.btn_start_stop = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_run", {15'd0, if_a.running}, 16'd0);

        // Clean press: running rises exactly 7 clocks after the raw edge
        if_a.btn_start_stop = 1'b1;
        repeat (6) @(negedge clk);
        check("press_lat6", {15'd0, if_a.running}, 16'd0);
        @(negedge clk);
        check("press_lat7", {15'd0, if_a.running}, 16'd1);
        if_a.btn_start_stop = 1'b0;

        // Pause 3 clocks into a tick, stay frozen, resume finishes the partial tick
        repeat (96) @(negedge clk);
        check("count_96", if_a.bcd_value, 16'h0009);
        tap(1'b1, 1'b0);
        check("pause_run", {15'd0, if_a.running}, 16'd0);
        check("pause_bcd", if_a.bcd_value, 16'h0010);
        repeat (50) @(negedge clk);
        check("frozen_bcd", if_a.bcd_value, 16'h0010);
        tap(1'b1, 1'b0);
        check("resume_run", {15'd0, if_a.running}, 16'd1);
        repeat (6) @(negedge clk);
        check("resume_6", if_a.bcd_value, 16'h0010);
        @(negedge clk);
        check("resume_7", if_a.bcd_value, 16'h0011);

        // Carry into the hundreds digit
        repeat (880) @(negedge clk);
        check("carry_99a", if_a.bcd_value, 16'h0099);
        repeat (9) @(negedge clk);
        check("carry_99b", if_a.bcd_value, 16'h0099);
        @(negedge clk);
        check("carry_100", if_a.bcd_value, 16'h0100);

        // Clear and start/stop in the same cycle: clear wins
        tap(1'b1, 1'b1);
        check("prio_bcd", if_a.bcd_value, 16'h0000);
        check("prio_run", {15'd0, if_a.running}, 16'd0);
        repeat (20) @(negedge clk);
        check("prio_hold", {15'd0, if_a.running}, 16'd0);

        // Vector table: clear, start, run N clocks, compare
        for (int i = 0; i < 7; i++) begin
            tap(1'b0, 1'b1);
            repeat (8) @(negedge clk);
            tap(1'b1, 1'b0);
            repeat (vecs[i].run_clks) @(negedge clk);
            check($sformatf("vec%0d_bcd", i), if_a.bcd_value, vecs[i].exp_bcd);
            check($sformatf("vec%0d_run", i), {15'd0, if_a.running}, {15'd0, vecs[i].exp_run});
        end

        // 99.99 wraps to 00.00 and keeps running
        if_f.btn_start_stop = 1'b1;
        repeat (7) @(negedge clk);
        if_f.btn_start_stop = 1'b0;
        check("fast_start", {15'd0, if_f.running}, 16'd1);
        repeat (9999) @(negedge clk);
        check("wrap_9999", if_f.bcd_value, 16'h9999);
        @(negedge clk);
        check("wrap_0000", if_f.bcd_value, 16'h0000);
        check("wrap_run", {15'd0, if_f.running}, 16'd1);

        // Randomised buttons and occasional reset against the model
        hold_ss  = 1;
        hold_clr = 20;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rand_bcd", if_a.bcd_value, to_bcd(m_hund));
            check("rand_run", {15'd0, if_a.running}, {15'd0, m_mode == 1});
            hold_ss--;
            if (hold_ss == 0) begin
                if_a.btn_start_stop = ~if_a.btn_start_stop;
                hold_ss = $urandom_range(1, 15);
            end
            hold_clr--;
            if (hold_clr == 0) begin
                if_a.btn_clear = ~if_a.btn_clear;
                hold_clr = if_a.btn_clear ? $urandom_range(1, 8) : $urandom_range(20, 200);
            end
            rst = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
